// File: rtl/vram_sdp_ctrl.sv
// Simple-dual-port video RAM: byte-enable word writes, fixed-latency pipelined
// reads (read-first on collision) and a self-timed clear engine that sweeps
// the whole array with a repeated fill byte.
//
// state | meaning
// IDLE  | normal operation, writes accepted, clr_start honoured
// CLEAR | sweeping one word per cycle with the fill pattern, writes stalled
module vram_sdp_ctrl #(
  parameter int WORD_ADDR_W  = 12,
  parameter int DATA_W       = 64,
  parameter int READ_LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WORD_ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [WORD_ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_data_valid,
  input  logic                     clr_start,
  input  logic [7:0]               clr_value,
  output logic                     clr_busy,
  output logic                     clr_done
);
  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 1 << WORD_ADDR_W;
  localparam logic [WORD_ADDR_W-1:0] LAST_ADDR = {WORD_ADDR_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [WORD_ADDR_W-1:0]  sweep_cnt, sweep_cnt_nxt;
  logic [7:0]              fill_byte, fill_byte_nxt;
  logic                    clr_done_nxt;
  logic                    clr_we;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid;

  assign wr_ready      = (state == IDLE);
  assign clr_busy      = (state == CLEAR);
  assign rd_data       = pipe_data[READ_LATENCY-1];
  assign rd_data_valid = pipe_valid[READ_LATENCY-1];

  // Next-state logic: start a sweep from IDLE, finish after the last word
  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    fill_byte_nxt = fill_byte;
    clr_done_nxt  = 1'b0;
    clr_we        = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt     = CLEAR;
          sweep_cnt_nxt = '0;
          fill_byte_nxt = clr_value;
        end
      end
      CLEAR: begin
        clr_we        = 1'b1;
        sweep_cnt_nxt = sweep_cnt + 1'b1;
        // Terminate on the last address rather than relying on wrap-around
        if (sweep_cnt == LAST_ADDR) begin
          state_nxt    = IDLE;
          clr_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, sweep counter, captured fill byte and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sweep_cnt <= '0;
      fill_byte <= '0;
      clr_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
      fill_byte <= fill_byte_nxt;
      clr_done  <= clr_done_nxt;
    end
  end

  // Array write port: clear sweep has priority (user writes are stalled then);
  // contents survive reset, but a reset edge suppresses the pending sweep write
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[sweep_cnt] <= {BYTES{fill_byte}};
    end else if (wr_valid && wr_ready) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read pipeline: sample array at issue (read-first), data stages only load
  // on valid so rd_data holds its last result between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= rd_en;
      if (rd_en) pipe_data[0] <= mem[rd_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

endmodule
